instruction_sequencer: RTL and testbench

//  Read side of the instruction memory. After the user has entered a program, the block

---
 rtl/instruction_sequencer_pkg.sv | 42 ++++
 rtl/instr_mem_read_port.sv | 36 +++
 rtl/instruction_sequencer.sv | 122 ++++++++++++
 tb/tb_instruction_sequencer.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction field layout, the halt
// opcode, sequencer states and the field decode helper.
package instruction_sequencer_pkg;

    localparam int unsigned InstrBits = 18;
    localparam int unsigned OpLsb     = 14;
    localparam int unsigned OpW       = 4;
    localparam int unsigned Rid1Lsb   = 11;
    localparam int unsigned Rid2Lsb   = 8;
    localparam int unsigned RidW      = 3;
    localparam int unsigned ImmLsb    = 0;
    localparam int unsigned ImmW      = 8;

    localparam logic [OpW-1:0] HALT_OP = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StIssue,
        StStepWait,
        StDone,
        StError
    } state_e;

    typedef struct packed {
        logic [OpW-1:0]  op;
        logic [RidW-1:0] rid1;
        logic [RidW-1:0] rid2;
        logic [ImmW-1:0] imm;
    } instr_t;

    function automatic instr_t decode(input logic [InstrBits-1:0] word);
        instr_t d;
        d.op   = word[OpLsb +: OpW];
        d.rid1 = word[Rid1Lsb +: RidW];
        d.rid2 = word[Rid2Lsb +: RidW];
        d.imm  = word[ImmLsb +: ImmW];
        return d;
    endfunction

endpackage

// File: rtl/instr_mem_read_port.sv
// Registered word mux over the flattened instruction store: data for addr appears one
// cycle after addr is presented; addresses beyond the store read as zero.
module instr_mem_read_port #(
    parameter int unsigned DEPTH   = 10,
    parameter int unsigned INSTR_W = 18,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DEPTH*INSTR_W-1:0] mem_flat,
    output logic [INSTR_W-1:0]       rd_data
);

    logic [INSTR_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (addr == ADDR_W'(k)) begin
                rd_data_d = mem_flat[k*INSTR_W +: INSTR_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/instruction_sequencer.sv
// Walks the PC over the stored program, decodes each fetched word and hands it to the
// execute stage over a valid/ready handshake, in free-run or single-step mode.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH   = 10,
    parameter int unsigned INSTR_W = 18,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DEPTH*INSTR_W-1:0] mem_flat,
    input  logic [ADDR_W-1:0]        instr_last,
    input  logic                     start,
    input  logic                     step_mode,
    input  logic                     step,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [3:0]               op_code,
    output logic [2:0]               reg_id1,
    output logic [2:0]               reg_id2,
    output logic [7:0]               imm_value,
    input  logic                     jump_valid,
    input  logic [ADDR_W-1:0]        jump_target,
    output logic [ADDR_W-1:0]        pc,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    instr_t              fields_q, fields_d;
    logic [INSTR_W-1:0]  rd_data;
    instr_t              rd_fields;
    state_e              after_issue;

    // The read port is always addressed by pc; the word sampled in FETCH is used in WAIT.
    instr_mem_read_port #(
        .DEPTH  (DEPTH),
        .INSTR_W(INSTR_W),
        .ADDR_W (ADDR_W)
    ) u_read_port (
        .clock   (clock),
        .reset   (reset),
        .addr    (pc_q),
        .mem_flat(mem_flat),
        .rd_data (rd_data)
    );

    assign rd_fields   = decode(rd_data);
    assign after_issue = step_mode ? StStepWait : StFetch;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fields_d = fields_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    if (instr_last > LastAddr) begin
                        state_d = StError;
                    end else begin
                        state_d = StFetch;
                        pc_d    = '0;
                    end
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
                fields_d = rd_fields;
                state_d  = (rd_fields.op == HALT_OP) ? StDone : StIssue;
            end
            StIssue: begin
                if (issue_ready) begin
                    if (jump_valid) begin
                        if (jump_target > instr_last) begin
                            state_d = StError;
                        end else begin
                            pc_d    = jump_target;
                            state_d = after_issue;
                        end
                    end else if (pc_q == instr_last) begin
                        state_d = StDone;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = after_issue;
                    end
                end
            end
            StStepWait: if (step) state_d = StFetch;
            StError:    state_d = StError;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            fields_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fields_q <= fields_d;
        end
    end

    assign issue_valid = (state_q == StIssue);
    assign op_code     = fields_q.op;
    assign reg_id1     = fields_q.rid1;
    assign reg_id2     = fields_q.rid2;
    assign imm_value   = fields_q.imm;
    assign pc          = pc_q;
    assign busy        = (state_q == StFetch) || (state_q == StWait) ||
                         (state_q == StIssue) || (state_q == StStepWait);
    assign done        = (state_q == StDone);
    assign error       = (state_q == StError);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed scenarios plus randomized programs
// scored against a program-walk reference model.
module tb_instruction_sequencer;

    logic          clock = 1'b0;
    logic          reset;
    logic [179:0]  mem_flat;
    logic [3:0]    instr_last;
    logic          start, step_mode, step, issue_ready, jump_valid;
    logic [3:0]    jump_target;
    logic          issue_valid, busy, done, error;
    logic [3:0]    op_code, pc;
    logic [2:0]    reg_id1, reg_id2;
    logic [7:0]    imm_value;
    logic [17:0]   fields;

    logic [17:0]   prog [10];
    logic [17:0]   exp_q [$];
    int            exp_pc;
    int            n_cmp = 0;
    int            n_fail = 0;

    always #5 clock = ~clock;
    assign fields = {op_code, reg_id1, reg_id2, imm_value};

    instruction_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .mem_flat   (mem_flat),
        .instr_last (instr_last),
        .start      (start),
        .step_mode  (step_mode),
        .step       (step),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .op_code    (op_code),
        .reg_id1    (reg_id1),
        .reg_id2    (reg_id2),
        .imm_value  (imm_value),
        .jump_valid (jump_valid),
        .jump_target(jump_target),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    function automatic logic [17:0] rand_word(input bit halt);
        logic [17:0] w;
        w = 18'($urandom);
        if (halt) w[17:14] = 4'hF;
        else if (w[17:14] == 4'hF) w[17:14] = 4'hE;
        return w;
    endfunction

    task automatic load_prog();
        for (int k = 0; k < 10; k++) mem_flat[k*18 +: 18] = prog[k];
    endtask

    task automatic load_spec_prog();
        for (int k = 0; k < 10; k++) prog[k] = 18'h0;
        prog[0] = 18'h0C1C0;
        prog[1] = 18'h04A05;
        prog[2] = 18'h08300;
        instr_last = 4'd2;
        load_prog();
    endtask

    // Reference: walk from address 0, stop before a halt word or after instr_last.
    task automatic model_seq();
        int  p;
        bit  fin;
        exp_q.delete();
        p = 0;
        fin = 0;
        while (!fin) begin
            if (prog[p][17:14] == 4'hF) fin = 1;
            else begin
                exp_q.push_back(prog[p]);
                if (p == int'(instr_last)) fin = 1;
                else p++;
            end
        end
        exp_pc = p;
    endtask

    task automatic do_reset();
        reset = 1; start = 0; step = 0; step_mode = 0; issue_ready = 0;
        jump_valid = 0; jump_target = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clock);
        start = 0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({issue_valid, busy, done, error} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {issue_valid, busy, done, error});
        end
        n_cmp++;
        if (fields !== 18'h0) begin
            n_fail++; $display("FAIL reset_fields: got %h want 0", fields);
        end
        n_cmp++;
        if (pc !== 4'h0) begin
            n_fail++; $display("FAIL reset_pc: got %0d want 0", pc);
        end
        step = 1;
        @(negedge clock);
        step = 0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_step: busy got %b want 0", busy);
        end
    endtask

    task automatic test_free_run();
        int cyc, first, last_hs, got;
        load_spec_prog();
        model_seq();
        step_mode = 0;
        issue_ready = 1;
        pulse_start();
        cyc = 1; first = -1; last_hs = -1; got = 0;
        while (!done && !error && cyc < 60) begin
            if (issue_valid) begin
                if (first < 0) begin
                    first = cyc;
                    n_cmp++;
                    if (fields !== {4'h3, 3'd0, 3'd1, 8'hC0}) begin
                        n_fail++; $display("FAIL fr_first_fields: got %h want 0c1c0", fields);
                    end
                end
                n_cmp++;
                if (got >= exp_q.size()) begin
                    n_fail++; $display("FAIL fr_extra_issue: got %h want none", fields);
                end else if (fields !== exp_q[got]) begin
                    n_fail++; $display("FAIL fr_issue%0d: got %h want %h", got, fields, exp_q[got]);
                end
                if (last_hs >= 0) begin
                    n_cmp++;
                    if (cyc - last_hs != 3) begin
                        n_fail++; $display("FAIL fr_spacing: got %0d want 3", cyc - last_hs);
                    end
                end
                last_hs = cyc;
                got++;
            end
            @(negedge clock);
            cyc++;
        end
        n_cmp++;
        if (first != 3) begin
            n_fail++; $display("FAIL fr_latency: got %0d want 3", first);
        end
        n_cmp++;
        if (got != 3 || done !== 1'b1 || pc !== 4'd2) begin
            n_fail++; $display("FAIL fr_end: issues %0d done %b pc %0d want 3 1 2", got, done, pc);
        end

        for (int it = 0; it < 6; it++) begin
            instr_last = 4'($urandom_range(0, 9));
            for (int k = 0; k < 10; k++) prog[k] = rand_word($urandom_range(0, 5) == 0);
            load_prog();
            model_seq();
            pulse_start();
            cyc = 0; got = 0;
            while (!done && !error && cyc < 300) begin
                issue_ready = ($urandom_range(0, 3) != 0);
                start = busy && ($urandom_range(0, 7) == 0);
                step = 1'($urandom_range(0, 1));
                if (issue_valid && issue_ready) begin
                    n_cmp++;
                    if (got >= exp_q.size()) begin
                        n_fail++; $display("FAIL rnd%0d_extra: got %h want none", it, fields);
                    end else if (fields !== exp_q[got]) begin
                        n_fail++; $display("FAIL rnd%0d_issue%0d: got %h want %h", it, got, fields,
                                           exp_q[got]);
                    end
                    got++;
                end
                @(negedge clock);
                cyc++;
            end
            start = 0; step = 0;
            n_cmp++;
            if (got != exp_q.size() || done !== 1'b1 || error !== 1'b0 || pc !== 4'(exp_pc)) begin
                n_fail++; $display("FAIL rnd%0d_end: issues %0d done %b err %b pc %0d want %0d 1 0 %0d",
                                   it, got, done, error, pc, exp_q.size(), exp_pc);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc, got;
        load_spec_prog();
        issue_ready = 0;
        pulse_start();
        cyc = 0;
        while (!issue_valid && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_cmp++;
            if (issue_valid !== 1'b1 || fields !== prog[0] || pc !== 4'd0) begin
                n_fail++; $display("FAIL bp_hold%0d: valid %b fields %h pc %0d want 1 %h 0", i,
                                   issue_valid, fields, pc, prog[0]);
            end
        end
        issue_ready = 1;
        @(negedge clock);
        n_cmp++;
        if (issue_valid !== 1'b0 || pc !== 4'd1) begin
            n_fail++; $display("FAIL bp_single_hs: valid %b pc %0d want 0 1", issue_valid, pc);
        end
        cyc = 0; got = 0;
        while (!done && cyc < 40) begin
            if (issue_valid) begin
                n_cmp++;
                if (got > 1 || fields !== prog[got + 1]) begin
                    n_fail++; $display("FAIL bp_drain%0d: got %h want %h", got, fields, prog[got + 1]);
                end
                got++;
            end
            @(negedge clock);
            cyc++;
        end
        n_cmp++;
        if (got != 2 || done !== 1'b1) begin
            n_fail++; $display("FAIL bp_end: issues %0d done %b want 2 1", got, done);
        end
    endtask

    task automatic test_single_step();
        int cyc;
        load_spec_prog();
        step_mode = 1;
        issue_ready = 1;
        pulse_start();
        cyc = 0;
        while (!issue_valid && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        n_cmp++;
        if (issue_valid !== 1'b1 || fields !== prog[0]) begin
            n_fail++; $display("FAIL ss_first: valid %b fields %h want 1 %h", issue_valid, fields, prog[0]);
        end
        @(negedge clock);
        issue_ready = 0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (issue_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL ss_park%0d: valid %b busy %b want 0 1", i, issue_valid, busy);
            end
            @(negedge clock);
        end
        step = 1;
        @(negedge clock);
        step = 0;
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if (issue_valid !== 1'b1 || fields !== prog[1] || pc !== 4'd1) begin
            n_fail++; $display("FAIL ss_second: valid %b fields %h pc %0d want 1 %h 1", issue_valid,
                               fields, pc, prog[1]);
        end
        step = 1;
        @(negedge clock);
        step = 0;
        n_cmp++;
        if (issue_valid !== 1'b1 || fields !== prog[1]) begin
            n_fail++; $display("FAIL ss_step_in_issue: valid %b fields %h want 1 %h", issue_valid,
                               fields, prog[1]);
        end
        issue_ready = 1;
        @(negedge clock);
        issue_ready = 0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (issue_valid !== 1'b0) begin
                n_fail++; $display("FAIL ss_extra_step%0d: valid got %b want 0", i, issue_valid);
            end
            @(negedge clock);
        end
        step = 1;
        @(negedge clock);
        step = 0;
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if (issue_valid !== 1'b1 || fields !== prog[2] || pc !== 4'd2) begin
            n_fail++; $display("FAIL ss_third: valid %b fields %h pc %0d want 1 %h 2", issue_valid,
                               fields, pc, prog[2]);
        end
        issue_ready = 1;
        @(negedge clock);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || pc !== 4'd2) begin
            n_fail++; $display("FAIL ss_end: done %b busy %b pc %0d want 1 0 2", done, busy, pc);
        end
        step_mode = 0;
    endtask

    task automatic test_jump();
        logic [17:0] ex [5];
        int cyc, got;
        bit seen;
        for (int k = 0; k < 10; k++) prog[k] = rand_word(0);
        instr_last = 4'd2;
        load_prog();
        ex[0] = prog[0]; ex[1] = prog[1]; ex[2] = prog[0]; ex[3] = prog[1]; ex[4] = prog[2];
        issue_ready = 1;
        pulse_start();
        cyc = 0; got = 0;
        while (!done && !error && cyc < 60) begin
            if (issue_valid) begin
                n_cmp++;
                if (got > 4 || fields !== ex[got]) begin
                    n_fail++; $display("FAIL jmp_issue%0d: got %h want %h", got, fields, ex[got % 5]);
                end
                jump_valid = (got == 1);
                jump_target = 4'd0;
                got++;
            end else begin
                // Outside a handshake the request must be ignored.
                jump_valid = 1;
                jump_target = 4'd2;
            end
            @(negedge clock);
            cyc++;
        end
        jump_valid = 0;
        n_cmp++;
        if (got != 5 || done !== 1'b1 || pc !== 4'd2) begin
            n_fail++; $display("FAIL jmp_end: issues %0d done %b pc %0d want 5 1 2", got, done, pc);
        end

        pulse_start();
        cyc = 0; got = 0;
        while (got < 2 && cyc < 30) begin
            jump_valid = 0;
            if (issue_valid) begin
                if (got == 1) begin
                    jump_valid = 1;
                    jump_target = 4'd7;
                end
                got++;
            end
            @(negedge clock);
            cyc++;
        end
        jump_valid = 0;
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0 || issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL jmp_oob: err %b busy %b valid %b want 1 0 0", error, busy, issue_valid);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (issue_valid) seen = 1;
            start = (i == 2);
            @(negedge clock);
        end
        start = 0;
        n_cmp++;
        if (seen || error !== 1'b1) begin
            n_fail++; $display("FAIL jmp_sticky: issued %b err %b want 0 1", seen, error);
        end

        do_reset();
        instr_last = 4'd12;
        pulse_start();
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL start_bad_last: err %b busy %b want 1 0", error, busy);
        end
        do_reset();
    endtask

    task automatic test_halt();
        int cyc, got;
        prog[0] = rand_word(0);
        prog[1] = rand_word(1);
        prog[2] = rand_word(0);
        instr_last = 4'd2;
        load_prog();
        model_seq();
        issue_ready = 1;
        for (int run = 0; run < 2; run++) begin
            pulse_start();
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b1 || pc !== 4'd0) begin
                n_fail++; $display("FAIL halt_restart%0d: done %b busy %b pc %0d want 0 1 0", run,
                                   done, busy, pc);
            end
            cyc = 0; got = 0;
            while (!done && !error && cyc < 40) begin
                if (issue_valid) begin
                    n_cmp++;
                    if (got >= exp_q.size()) begin
                        n_fail++; $display("FAIL halt_extra%0d: got %h want none", run, fields);
                    end else if (fields !== exp_q[got]) begin
                        n_fail++; $display("FAIL halt_issue%0d: got %h want %h", run, fields, exp_q[got]);
                    end
                    got++;
                end
                @(negedge clock);
                cyc++;
            end
            n_cmp++;
            if (got != 1 || done !== 1'b1 || pc !== 4'd1) begin
                n_fail++; $display("FAIL halt_end%0d: issues %0d done %b pc %0d want 1 1 1", run,
                                   got, done, pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc, got;
        bit seen;
        load_spec_prog();
        model_seq();
        issue_ready = 0;
        pulse_start();
        cyc = 0;
        while (!issue_valid && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        reset = 1;
        @(negedge clock);
        reset = 0;
        n_cmp++;
        if ({issue_valid, busy, done, error, pc, fields} !== 26'h0) begin
            n_fail++; $display("FAIL mid_reset: got %h want 0", {issue_valid, busy, done, error, pc, fields});
        end
        issue_ready = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (issue_valid) seen = 1;
            @(negedge clock);
        end
        n_cmp++;
        if (seen) begin
            n_fail++; $display("FAIL mid_reset_quiet: issued %b want 0", seen);
        end
        pulse_start();
        cyc = 0; got = 0;
        while (!done && !error && cyc < 40) begin
            start = busy;
            if (issue_valid) begin
                n_cmp++;
                if (got >= exp_q.size()) begin
                    n_fail++; $display("FAIL busy_start_extra: got %h want none", fields);
                end else if (fields !== exp_q[got] || pc !== 4'(got)) begin
                    n_fail++; $display("FAIL busy_start%0d: got %h pc %0d want %h %0d", got, fields,
                                       pc, exp_q[got], got);
                end
                got++;
            end
            @(negedge clock);
            cyc++;
        end
        start = 0;
        n_cmp++;
        if (got != 3 || done !== 1'b1 || pc !== 4'd2) begin
            n_fail++; $display("FAIL busy_start_end: issues %0d done %b pc %0d want 3 1 2", got, done, pc);
        end
    endtask

    initial begin
        mem_flat = '0;
        instr_last = 4'd0;
        do_reset();
        test_reset();
        test_free_run();
        test_backpressure();
        test_single_step();
        test_jump();
        test_halt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
